// File: rtl/pwm_duty_ctrl.sv
// Front-panel PWM duty controller: debounced up/down keys step a 0..10 level that drives PWM and display codes.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat stepping on both keys.

module pwm_duty_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic step
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    logic        s1, s2;
    logic [1:0]  flush;
    logic        armed;
    state_t      state, state_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic        step_nx;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] hcnt, hcnt_nx;
`endif

    // A key held through reset must be seen released before a press counts:
    // armed only sets once the synchronizer has refilled from the real pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            flush <= '0;
            armed <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            hcnt  <= '0;
`endif
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            flush <= {flush[0], 1'b1};
            armed <= armed | (flush[1] & s2);
            state <= state_nx;
            cnt   <= cnt_nx;
            step  <= step_nx;
`ifdef AUTO_REPEAT_EN
            hcnt  <= hcnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step_nx  = 1'b0;
`ifdef AUTO_REPEAT_EN
        hcnt_nx  = '0;
`endif
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (armed && !s2) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    step_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + DW'(1);
                end
            end
            HELD: begin
                cnt_nx = '0;
                if (s2) begin
                    state_nx = REL_WAIT;
                    cnt_nx   = DW'(1);
                end
`ifdef AUTO_REPEAT_EN
                else if (hcnt == RP_LAST) begin
                    step_nx = 1'b1;
                end else begin
                    hcnt_nx = hcnt + RW'(1);
                end
`endif
            end
            REL_WAIT: begin
                if (!s2) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + DW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

module pwm_duty_ctrl #(
    parameter int SLOT_CYCLES     = 5000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    output logic       pwm_out,
    output logic [3:0] level,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic       period_tick
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
    localparam logic [3:0] LEVEL_MAX = 4'd10;
    localparam logic [3:0] IDX_LAST  = 4'd9;

    if (SLOT_CYCLES < 2) begin : g_bad_slot
        $error("SLOT_CYCLES must be at least 2");
    end

    logic          up_step, dn_step;
    logic [3:0]    level_nx;
    logic [SW-1:0] slot_cnt;
    logic [3:0]    slot_idx;
    logic [3:0]    active_level;
    logic          slot_wrap;

    pwm_duty_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db_up (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_up_n),
        .step (up_step)
    );

    pwm_duty_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_dn_n),
        .step (dn_step)
    );

    always_comb begin
        level_nx = level;
        if (up_step && !dn_step && level < LEVEL_MAX) begin
            level_nx = level + 4'd1;
        end else if (dn_step && !up_step && level != 4'd0) begin
            level_nx = level - 4'd1;
        end
    end

    // Digits load from level_nx so they change on the same edge as level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= '0;
            digit0 <= '0;
            digit1 <= '0;
            digit2 <= '0;
        end else begin
            level  <= level_nx;
            digit0 <= level_nx;
            digit1 <= level_nx;
            digit2 <= level_nx;
        end
    end

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign period_tick = slot_wrap && (slot_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt     <= '0;
            slot_idx     <= '0;
            active_level <= '0;
            pwm_out      <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
            if (slot_wrap) begin
                slot_idx <= (slot_idx == IDX_LAST) ? '0 : slot_idx + 4'd1;
            end
            if (period_tick) begin
                active_level <= level;
            end
            pwm_out <= (slot_idx < active_level);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: table-driven key presses plus a per-period PWM duty scoreboard.
// Define AUTO_REPEAT_EN for both bench and design to include the hold-repeat sequence.

module tb_pwm_duty_ctrl;

    localparam int SLOT = 4;
    localparam int DEB  = 8;
    localparam int REP  = 20;
    localparam int PERIOD = 10 * SLOT;

    logic       clk;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic       pwm_out;
    logic [3:0] level;
    logic [3:0] digit0, digit1, digit2;
    logic       period_tick;

    int errors = 0;
    int checks = 0;

    pwm_duty_ctrl #(
        .SLOT_CYCLES    (SLOT),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up_n   (btn_up_n),
        .btn_dn_n   (btn_dn_n),
        .pwm_out    (pwm_out),
        .level      (level),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // PWM scoreboard. A sample at negedge k carries pwm_out for the counter
    // state of cycle k-1, so a period closes one sample after its tick.
    // Each tick pushes the duty the following period must show (4 clocks per
    // level step); the window closing right after a push belongs to the
    // previous push, hence the pop needs two entries queued.
    int exp_q[$];
    int highs = 0;
    int plen  = 0;
    bit prev_tick = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            highs = 0;
            plen = 0;
            prev_tick = 1'b0;
        end else begin
            highs += int'(pwm_out);
            plen++;
            if (prev_tick) begin
                if (exp_q.size() >= 2) begin
                    check("pwm_high_count", highs, exp_q.pop_front());
                    check("period_len", plen, PERIOD);
                end
                highs = 0;
                plen = 0;
            end
            if (period_tick) exp_q.push_back(SLOT * int'(level));
            prev_tick = period_tick;
        end
    end

    task automatic press(input bit up, input bit dn);
        btn_up_n = !up;
        btn_dn_n = !dn;
        repeat (12) @(negedge clk);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (period_tick) begin
                found = 1'b1;
                return;
            end
        end
        check("tick_timeout", 0, 1);
    endtask

    // Counts the pwm_out highs belonging to the period that starts after the tick just seen.
    task automatic count_period(output int n);
        n = 0;
        @(negedge clk);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            n += int'(pwm_out);
        end
    endtask

    typedef enum int {OP_UP, OP_DN, OP_BOTH} op_t;
    typedef struct {
        op_t        op;
        int         n;
        int         settle;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic apply_row(input int idx);
        vec_t v;
        v = vecs[idx];
        for (int k = 0; k < v.n; k++) begin
            press(v.op != OP_DN, v.op != OP_UP);
        end
        repeat (v.settle) @(negedge clk);
        check($sformatf("row%0d_level", idx), int'(level), int'(v.exp));
        check($sformatf("row%0d_digit0", idx), int'(digit0), int'(v.exp));
        check($sformatf("row%0d_digit1", idx), int'(digit1), int'(v.exp));
        check($sformatf("row%0d_digit2", idx), int'(digit2), int'(v.exp));
    endtask

    initial begin
        bit found;
        int n_cur, n_next;

        vecs[0] = '{OP_UP,   12, 100, 4'd10};
        vecs[1] = '{OP_DN,    1, 100, 4'd9};
        vecs[2] = '{OP_DN,    9, 100, 4'd0};
        vecs[3] = '{OP_DN,    1, 100, 4'd0};
        vecs[4] = '{OP_UP,    3, 100, 4'd3};
        vecs[5] = '{OP_BOTH,  1, 100, 4'd3};
        vecs[6] = '{OP_UP,    3, 100, 4'd10};
        vecs[7] = '{OP_DN,   10, 100, 4'd0};
        vecs[8] = '{OP_UP,    1, 100, 4'd1};

        rst_n    = 1'b0;
        btn_up_n = 1'b0;
        btn_dn_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", int'(level), 0);
        check("rst_digits", int'({digit2, digit1, digit0}), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_tick", int'(period_tick), 0);
        rst_n = 1'b1;

        // Keys still held from reset must not step the level.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("held_thru_rst_level", int'(level), 0);
            check("held_thru_rst_pwm", int'(pwm_out), 0);
        end
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (12) @(negedge clk);
        check("after_release_level", int'(level), 0);

        // Bounce: 5 low, 2 high, 10 low yields a single increment.
        btn_up_n = 1'b0;
        repeat (5) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (2) @(negedge clk);
        btn_up_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (14) @(negedge clk);
        check("bounce_level", int'(level), 1);
        check("bounce_digit0", int'(digit0), 1);
        check("bounce_digit1", int'(digit1), 1);
        check("bounce_digit2", int'(digit2), 1);

        for (int i = 0; i < 6; i++) apply_row(i);

        // Level 3 to 7 mid-period: the running period keeps the old duty.
        wait_tick(found);
        repeat (10) @(negedge clk);
        wait_tick(found);
        fork
            count_period(n_cur);
            begin
                repeat (8) @(negedge clk);
                for (int k = 0; k < 4; k++) press(1'b1, 1'b0);
            end
        join
        check("boundary_cur_period", n_cur, 12);
        check("boundary_level", int'(level), 7);
        wait_tick(found);
        count_period(n_next);
        check("boundary_next_period", n_next, 28);

        apply_row(6);
        wait_tick(found);
        count_period(n_cur);
        check("const_high_l10", n_cur, PERIOD);

        apply_row(7);
        wait_tick(found);
        count_period(n_cur);
        check("const_low_l0", n_cur, 0);

`ifdef AUTO_REPEAT_EN
        btn_up_n = 1'b0;
        repeat (DEB + 60) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (14) @(negedge clk);
        check("auto_repeat_level", int'(level), 4);
        for (int k = 0; k < 4; k++) press(1'b0, 1'b1);
        check("auto_repeat_back_to_0", int'(level), 0);
`endif

        apply_row(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
